// File: rtl/bcomp_pkg.sv
// Shared constants for the BCOMP condition unit: cond vector width, bit positions and packing helper.
// Used by bcomp_cond_unit (optional feature macro: BCOMP_COND_PARITY_EN).
package bcomp_pkg;

  localparam int COND_W   = 18;
  localparam int COND_RUN = 1;
  localparam int COND_IRQ = 2;
  localparam int COND_C   = 10;
  localparam int COND_Z   = 11;
  localparam int COND_N   = 13;
  localparam int COND_V   = 14;

  // flags word layout is {N,Z,C,V}
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  localparam int IR_OP_HI      = 15;
  localparam int IR_OP_LO      = 9;
  localparam int IR_MID        = 8;
  localparam int IR_LOW_HI     = 7;
  localparam int IR_LOW_LO     = 4;
  localparam int COND_OP_BASE  = 3;
  localparam int COND_MID      = 12;
  localparam int COND_LOW_BASE = 15;

  function automatic logic [COND_W:1] pack_cond(input logic run, input logic irq,
                                                input logic [15:0] ir, input logic [3:0] flags);
    logic [COND_W:1] c;
    c = '0;
    c[COND_RUN] = run;
    c[COND_IRQ] = irq;
    // opcode bits land in descending order: cond[3] is the instruction MSB
    for (int i = 0; i <= IR_OP_HI - IR_OP_LO; i++)
      c[COND_OP_BASE + i] = ir[IR_OP_HI - i];
    c[COND_MID] = ir[IR_MID];
    for (int i = 0; i <= IR_LOW_HI - IR_LOW_LO; i++)
      c[COND_LOW_BASE + i] = ir[IR_LOW_HI - i];
    c[COND_C] = flags[FLAG_C];
    c[COND_Z] = flags[FLAG_Z];
    c[COND_N] = flags[FLAG_N];
    c[COND_V] = flags[FLAG_V];
    return c;
  endfunction

endpackage

// File: rtl/bcomp_ir_fifo.sv
// Synchronous instruction buffer with push/pop/full/empty/count.
// With BCOMP_COND_PARITY_EN defined each entry also carries a parity-bad bit.
module bcomp_ir_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           wr_data,
`ifdef BCOMP_COND_PARITY_EN
  input  logic                   wr_bad,
  output logic                   rd_bad,
`endif
  input  logic                   pop,
  output logic [W-1:0]           rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // power-of-2 depth lets the pointers wrap by plain overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

`ifdef BCOMP_COND_PARITY_EN
  logic bad_mem [DEPTH];

  assign rd_bad = bad_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) bad_mem[wr_ptr] <= wr_bad;
  end
`endif

endmodule

// File: rtl/bcomp_cond_unit.sv
// Condition stage feeding the BCOMP controller x1..x18 inputs: instruction buffer, flags, run latch, irq sync.
// Optional BCOMP_COND_PARITY_EN adds odd-parity checking on pushed words and the parity_err output.
module bcomp_cond_unit
  import bcomp_pkg::*;
#(
  parameter int IR_W        = 16,
  parameter int FIFO_DEPTH  = 2,
  parameter int STALL_MAX   = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IR_W-1:0] ir_data,
  input  logic            ir_valid,
  output logic            ir_ready,
  input  logic            ir_pop,
  input  logic            flag_we,
  input  logic [3:0]      flags_in,
  input  logic            start,
  input  logic            halt,
  input  logic            irq_req,
  input  logic            irq_ack,
  output logic [COND_W:1] cond,
  output logic            cond_valid,
  output logic            stall_err
`ifdef BCOMP_COND_PARITY_EN
  ,
  output logic            parity_err
`endif
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int STALL_W = $clog2(STALL_MAX + 1);

  logic                 push, full, empty, stall_hit, irq_rise;
  logic [IR_W-1:0]      head;
  logic [CNT_W-1:0]     count;
  logic [3:0]           flags_q;
  logic                 run_q, irq_pend_q;
  logic [SYNC_STAGES:0] sync_q;
  logic [STALL_W-1:0]   stall_cnt;
  logic [COND_W:1]      cond_d;

  assign ir_ready   = !full;
  assign push       = ir_valid && ir_ready;
  assign cond_valid = (count != '0);

`ifdef BCOMP_COND_PARITY_EN
  logic wr_bad, head_bad;
  assign wr_bad = ~^ir_data;
`endif

  bcomp_ir_fifo #(.W(IR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (ir_data),
`ifdef BCOMP_COND_PARITY_EN
    .wr_bad  (wr_bad),
    .rd_bad  (head_bad),
`endif
    .pop     (ir_pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // extra flop past the synchroniser gives the previous level for edge detection
  assign irq_rise  = sync_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES];
  assign stall_hit = run_q && empty && (stall_cnt == STALL_W'(STALL_MAX));

  always_comb begin
    cond_d = pack_cond(run_q, irq_pend_q, empty ? 16'h0000 : head[15:0], flags_q);
`ifdef BCOMP_COND_PARITY_EN
    if (!empty && head_bad) cond_d = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q    <= '0;
      run_q      <= 1'b0;
      irq_pend_q <= 1'b0;
      sync_q     <= '0;
      stall_cnt  <= '0;
      stall_err  <= 1'b0;
      cond       <= '0;
    end else begin
      if (flag_we) flags_q <= flags_in;
      if (halt || stall_hit) run_q <= 1'b0;
      else if (start)        run_q <= 1'b1;
      sync_q <= {sync_q[SYNC_STAGES-1:0], irq_req};
      if (irq_rise)     irq_pend_q <= 1'b1;
      else if (irq_ack) irq_pend_q <= 1'b0;
      if (!run_q || !empty) stall_cnt <= '0;
      else if (!stall_hit)  stall_cnt <= stall_cnt + 1'b1;
      if (stall_hit) stall_err <= 1'b1;
      cond <= cond_d;
    end
  end

`ifdef BCOMP_COND_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= push && wr_bad;
  end
`endif

endmodule

// File: tb/tb_bcomp_cond_unit.sv
// Testbench for bcomp_cond_unit: directed vector table, irq/stall/reset sequences and
// randomized traffic checked against a queue-based reference model.
module tb_bcomp_cond_unit;

  localparam int S     = 2;
  localparam int SMAX  = 255;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir_data;
  logic        ir_valid, ir_pop, flag_we, start, halt, irq_req, irq_ack;
  logic [3:0]  flags_in;
  logic [18:1] cond;
  logic        cond_valid, ir_ready, stall_err;
`ifdef BCOMP_COND_PARITY_EN
  logic        parity_err;
`endif

  bcomp_cond_unit dut (
    .clk        (clk),
    .rst        (rst),
    .ir_data    (ir_data),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .ir_pop     (ir_pop),
    .flag_we    (flag_we),
    .flags_in   (flags_in),
    .start      (start),
    .halt       (halt),
    .irq_req    (irq_req),
    .irq_ack    (irq_ack),
    .cond       (cond),
    .cond_valid (cond_valid),
    .stall_err  (stall_err)
`ifdef BCOMP_COND_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state: buffer as a queue of {bad, word}
  logic [16:0] mq[$];
  logic [3:0]  m_flags;
  bit          m_run, m_pend, m_err, m_perr;
  int          m_stall;
  bit          m_hist[$];
  logic [18:1] m_cond;
  int          src_tab[1:18];

  typedef struct {
    logic [15:0] d;
    logic        v, pop, we;
    logic [3:0]  f;
    logic        st, hl;
    logic [17:0] exp_cond;
    logic        exp_valid, exp_ready;
  } vec_t;

  vec_t tab[14];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic v, input logic pop, input logic we,
                               input logic [3:0] f, input logic st, input logic hl,
                               input logic irq, input logic ack);
    ir_data = d; ir_valid = v; ir_pop = pop; flag_we = we; flags_in = f;
    start = st; halt = hl; irq_req = irq; irq_ack = ack;
  endtask

  task automatic modelReset();
    mq.delete();
    m_flags = '0; m_run = 0; m_pend = 0; m_err = 0; m_perr = 0; m_stall = 0; m_cond = '0;
    m_hist.delete();
    for (int i = 0; i < S + 2; i++) m_hist.push_back(1'b0);
  endtask

  // src_tab: 0..15 = instruction bit, 100+k = flags[k], 200 = run, 201 = irq pending
  function automatic logic [18:1] modelCond();
    logic [18:1] c;
    logic [16:0] h;
    int s;
    c = '0;
    h = (mq.size() != 0) ? mq[0] : 17'h0;
    if (h[16]) return '0;
    for (int i = 1; i <= 18; i++) begin
      s = src_tab[i];
      if (s == 200)      c[i] = m_run;
      else if (s == 201) c[i] = m_pend;
      else if (s >= 100) c[i] = m_flags[s-100];
      else               c[i] = h[s];
    end
    return c;
  endfunction

  task automatic stepCycle();
    logic [18:1] next_cond;
    bit empty, do_push, do_pop, hit, rise, wbad;
    @(posedge clk); #1;
    next_cond = modelCond();
    empty   = (mq.size() == 0);
    do_push = ir_valid && (mq.size() < DEPTH);
    do_pop  = ir_pop && !empty;
    hit     = m_run && empty && (m_stall == SMAX);
    m_stall = (!m_run || !empty) ? 0 : ((m_stall < SMAX) ? m_stall + 1 : m_stall);
    if (hit) m_err = 1;
    if (halt || hit) m_run = 0;
    else if (start)  m_run = 1;
    m_hist.push_front(irq_req);
    rise = m_hist[S] && !m_hist[S+1];
    void'(m_hist.pop_back());
    if (rise)         m_pend = 1;
    else if (irq_ack) m_pend = 0;
    if (flag_we) m_flags = flags_in;
`ifdef BCOMP_COND_PARITY_EN
    wbad = ~^ir_data;
`else
    wbad = 0;
`endif
    m_perr = do_push && wbad;
    if (do_pop)  void'(mq.pop_front());
    if (do_push) mq.push_back({wbad, ir_data});
    m_cond = next_cond;
    checkOutput("model_cond", 32'(cond), 32'(m_cond));
    checkOutput("model_cond_valid", 32'(cond_valid), 32'(mq.size() != 0));
    checkOutput("model_ir_ready", 32'(ir_ready), 32'(mq.size() < DEPTH));
    checkOutput("model_stall_err", 32'(stall_err), 32'(m_err));
`ifdef BCOMP_COND_PARITY_EN
    checkOutput("model_parity_err", 32'(parity_err), 32'(m_perr));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(16'h0, 0, 0, 0, 4'h0, 0, 0, irq_req, 0);
      stepCycle();
    end
  endtask

  initial begin
    src_tab = '{200, 201, 15, 14, 13, 12, 11, 10, 9, 101, 102, 8, 103, 100, 7, 6, 5, 4};

    // d, v, pop, we, f, st, hl, exp_cond, exp_valid, exp_ready
    tab[0]  = '{16'h0000, 0, 0, 0, 4'h0, 0, 0, 18'h00000, 0, 1};
    tab[1]  = '{16'hF0F0, 1, 0, 0, 4'h0, 0, 0, 18'h00000, 1, 1};
    tab[2]  = '{16'h0000, 0, 0, 0, 4'h0, 0, 0, 18'h3C03C, 1, 1};
    tab[3]  = '{16'h1234, 1, 0, 0, 4'h0, 0, 0, 18'h3C03C, 1, 0};
    tab[4]  = '{16'hFFFF, 1, 1, 0, 4'h0, 0, 0, 18'h3C03C, 1, 1};
    tab[5]  = '{16'h8421, 1, 1, 0, 4'h0, 0, 0, 18'h30120, 1, 1};
    tab[6]  = '{16'h0000, 0, 0, 0, 4'h0, 0, 0, 18'h10084, 1, 1};
    tab[7]  = '{16'h0000, 0, 1, 0, 4'h0, 0, 0, 18'h10084, 0, 1};
    tab[8]  = '{16'h0000, 0, 0, 1, 4'hA, 0, 0, 18'h00000, 0, 1};
    tab[9]  = '{16'h0000, 0, 0, 0, 4'h0, 0, 0, 18'h01200, 0, 1};
    tab[10] = '{16'h0000, 0, 0, 0, 4'h0, 1, 0, 18'h01200, 0, 1};
    tab[11] = '{16'h0000, 0, 0, 0, 4'h0, 0, 0, 18'h01201, 0, 1};
    tab[12] = '{16'h0000, 0, 0, 0, 4'h0, 1, 1, 18'h01201, 0, 1};
    tab[13] = '{16'h0000, 0, 0, 0, 4'h0, 0, 0, 18'h01200, 0, 1};

    rst = 1'b1;
    applyStimulus(16'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    #12;
    checkOutput("reset_cond", 32'(cond), 32'h0);
    checkOutput("reset_cond_valid", 32'(cond_valid), 32'h0);
    checkOutput("reset_ir_ready", 32'(ir_ready), 32'h1);
    checkOutput("reset_stall_err", 32'(stall_err), 32'h0);
    #5 rst = 1'b0;
    modelReset();

`ifndef BCOMP_COND_PARITY_EN
    for (int i = 0; i < 14; i++) begin
      applyStimulus(tab[i].d, tab[i].v, tab[i].pop, tab[i].we, tab[i].f, tab[i].st, tab[i].hl, 0, 0);
      stepCycle();
      checkOutput($sformatf("vec%0d_cond", i), 32'(cond), 32'(tab[i].exp_cond));
      checkOutput($sformatf("vec%0d_valid", i), 32'(cond_valid), 32'(tab[i].exp_valid));
      checkOutput($sformatf("vec%0d_ready", i), 32'(ir_ready), 32'(tab[i].exp_ready));
    end
`endif

    // irq latency, ack clearing, and ack colliding with a fresh edge
    applyStimulus(16'h0, 0, 0, 0, 4'h0, 0, 0, 1, 0);
    for (int i = 1; i <= S + 1; i++) begin
      stepCycle();
      checkOutput($sformatf("irq_lat_e%0d", i), 32'(cond[2]), 32'h0);
    end
    stepCycle();
    checkOutput("irq_lat_set", 32'(cond[2]), 32'h1);
    applyStimulus(16'h0, 0, 0, 0, 4'h0, 0, 0, 1, 1);
    stepCycle();
    applyStimulus(16'h0, 0, 0, 0, 4'h0, 0, 0, 1, 0);
    stepCycle();
    checkOutput("irq_ack_clear", 32'(cond[2]), 32'h0);
    applyStimulus(16'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    idle(4);
    applyStimulus(16'h0, 0, 0, 0, 4'h0, 0, 0, 1, 0);
    stepCycle();
    stepCycle();
    applyStimulus(16'h0, 0, 0, 0, 4'h0, 0, 0, 1, 1);
    stepCycle();
    checkOutput("irq_edge_ack_pre", 32'(cond[2]), 32'h0);
    applyStimulus(16'h0, 0, 0, 0, 4'h0, 0, 0, 1, 0);
    stepCycle();
    checkOutput("irq_edge_beats_ack", 32'(cond[2]), 32'h1);
    applyStimulus(16'h0, 0, 0, 0, 4'h0, 0, 0, 0, 1);
    stepCycle();
    idle(1);
    checkOutput("irq_ack_clear2", 32'(cond[2]), 32'h0);

`ifdef BCOMP_COND_PARITY_EN
    applyStimulus(16'h0003, 1, 0, 0, 4'h0, 0, 0, 0, 0);
    stepCycle();
    checkOutput("parity_err_pulse", 32'(parity_err), 32'h1);
    idle(1);
    checkOutput("parity_err_clear", 32'(parity_err), 32'h0);
    checkOutput("parity_cond_zero", 32'(cond), 32'h0);
    applyStimulus(16'h0, 0, 1, 0, 4'h0, 0, 0, 0, 0);
    stepCycle();
`endif

    for (int i = 0; i < 400; i++) begin
      applyStimulus(16'($urandom), $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) == 0, 4'($urandom), $urandom_range(0, 7) == 0,
                    $urandom_range(0, 15) == 0,
                    ($urandom_range(0, 5) == 0) ? !irq_req : irq_req,
                    $urandom_range(0, 7) == 0);
      stepCycle();
    end

    // asynchronous reset mid-operation with a word buffered and run set
    applyStimulus(16'hABCD, 1, 0, 1, 4'hF, 1, 0, 0, 0);
    stepCycle();
    idle(1);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_cond", 32'(cond), 32'h0);
    checkOutput("midrst_cond_valid", 32'(cond_valid), 32'h0);
    checkOutput("midrst_ir_ready", 32'(ir_ready), 32'h1);
    checkOutput("midrst_stall_err", 32'(stall_err), 32'h0);
    #1 rst = 1'b0;
    modelReset();
    idle(1);

    // stall: run with an empty buffer until the counter saturates
    applyStimulus(16'h0, 0, 0, 0, 4'h0, 1, 0, 0, 0);
    stepCycle();
    idle(SMAX);
    checkOutput("stall_before", 32'(stall_err), 32'h0);
    checkOutput("stall_run_before", 32'(cond[1]), 32'h1);
    idle(1);
    checkOutput("stall_hit", 32'(stall_err), 32'h1);
    idle(1);
    checkOutput("stall_run_clear", 32'(cond[1]), 32'h0);
    checkOutput("stall_sticky", 32'(stall_err), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
